// File: rtl/bsg_axil_master_cmd.sv
// Single-outstanding AXI-Lite initiator: converts a valid/ready command stream into
// AXI-Lite read/write transactions and returns one response per command on valid/yumi.
module bsg_axil_master_cmd #(
  parameter logic [31:0] axil_base_addr_p = 32'h0000_0000,
  parameter int unsigned err_cnt_width_p  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic [110:0]               m_axil_bus_o,
  input  logic [40:0]                m_axil_bus_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic                       we_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                data_i,
  input  logic [3:0]                 wstrb_i,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic                       we_o,
  output logic [31:0]                data_o,
  output logic [1:0]                 resp_o,
  output logic [err_cnt_width_p-1:0] err_cnt_o
);

  typedef struct packed {
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axil_mosi_s;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } axil_miso_s;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  function automatic logic [err_cnt_width_p-1:0] err_next(
    input logic [err_cnt_width_p-1:0] cnt,
    input logic [1:0]                 resp
  );
    if (resp == 2'b00) begin
      err_next = cnt;
    end else if (&cnt) begin
      err_next = cnt;
    end else begin
      err_next = cnt + {{(err_cnt_width_p-1){1'b0}}, 1'b1};
    end
  endfunction

  axil_miso_s miso_s;
  axil_mosi_s mosi_s;

  state_e                     state_q,   state_d;
  logic                       ready_q,   ready_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q,  wvalid_d;
  logic                       arvalid_q, arvalid_d;
  logic                       bready_q,  bready_d;
  logic                       rready_q,  rready_d;
  logic [31:0]                addr_q,    addr_d;
  logic [31:0]                wdata_q,   wdata_d;
  logic [3:0]                 wstrb_q,   wstrb_d;
  logic                       v_q,       v_d;
  logic                       we_q,      we_d;
  logic [31:0]                data_q,    data_d;
  logic [1:0]                 resp_q,    resp_d;
  logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;
  logic                       aw_done_s, w_done_s;

  assign miso_s = m_axil_bus_i;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    v_d       = v_q;
    we_d      = we_q;
    data_d    = data_q;
    resp_d    = resp_q;
    err_cnt_d = err_cnt_q;
    aw_done_s = 1'b0;
    w_done_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (v_i && ready_q) begin
          addr_d  = addr_i + axil_base_addr_p;
          wdata_d = data_i;
          wstrb_d = wstrb_i;
          if (we_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      // aw and w retire independently; leave only once both have handshaken
      WR: begin
        aw_done_s = ~awvalid_q | miso_s.awready;
        w_done_s  = ~wvalid_q  | miso_s.wready;
        awvalid_d = awvalid_q & ~miso_s.awready;
        wvalid_d  = wvalid_q  & ~miso_s.wready;
        if (aw_done_s && w_done_s) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else begin
          state_d  = WR;
        end
      end

      WR_RESP: begin
        if (miso_s.bvalid) begin
          state_d   = RSP;
          bready_d  = 1'b0;
          v_d       = 1'b1;
          we_d      = 1'b1;
          data_d    = 32'h0000_0000;
          resp_d    = miso_s.bresp;
          err_cnt_d = err_next(err_cnt_q, miso_s.bresp);
        end else begin
          state_d   = WR_RESP;
        end
      end

      RD_ADDR: begin
        if (miso_s.arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d   = RD_ADDR;
        end
      end

      RD_DATA: begin
        if (miso_s.rvalid) begin
          state_d   = RSP;
          rready_d  = 1'b0;
          v_d       = 1'b1;
          we_d      = 1'b0;
          data_d    = miso_s.rdata;
          resp_d    = miso_s.rresp;
          err_cnt_d = err_next(err_cnt_q, miso_s.rresp);
        end else begin
          state_d   = RD_DATA;
        end
      end

      RSP: begin
        if (yumi_i) begin
          state_d = IDLE;
          v_d     = 1'b0;
        end else begin
          state_d = RSP;
        end
      end

      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        v_d       = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops every valid immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      v_q       <= 1'b0;
      we_q      <= 1'b0;
      data_q    <= 32'h0000_0000;
      resp_q    <= 2'b00;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      v_q       <= v_d;
      we_q      <= we_d;
      data_q    <= data_d;
      resp_q    <= resp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mosi_s.awaddr  = addr_q;
  assign mosi_s.awprot  = 3'b000;
  assign mosi_s.awvalid = awvalid_q;
  assign mosi_s.wdata   = wdata_q;
  assign mosi_s.wstrb   = wstrb_q;
  assign mosi_s.wvalid  = wvalid_q;
  assign mosi_s.bready  = bready_q;
  assign mosi_s.araddr  = addr_q;
  assign mosi_s.arprot  = 3'b000;
  assign mosi_s.arvalid = arvalid_q;
  assign mosi_s.rready  = rready_q;

  assign m_axil_bus_o = mosi_s;
  assign ready_o      = ready_q;
  assign v_o          = v_q;
  assign we_o         = we_q;
  assign data_o       = data_q;
  assign resp_o       = resp_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_bsg_axil_master_cmd.sv
// Bench for bsg_axil_master_cmd: behavioural AXI-Lite slave with per-command delays,
// table-driven commands with a response scoreboard, plus reset/base-address sequences.
`timescale 1ns/1ps
module tb_bsg_axil_master_cmd;

  typedef struct packed {
    logic [31:0] awaddr; logic [2:0] awprot; logic awvalid;
    logic [31:0] wdata;  logic [3:0] wstrb;  logic wvalid; logic bready;
    logic [31:0] araddr; logic [2:0] arprot; logic arvalid; logic rready;
  } mosi_t;

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
    int aw_dly; int w_dly; int b_dly; int ar_dly; int r_dly;
    logic [1:0] resp; logic [31:0] rdata; int yumi_dly;
    logic [31:0] exp_data; logic [1:0] exp_resp; int exp_lat;
  } vec_t;

  typedef struct {
    logic we; logic [31:0] data; logic [1:0] resp; int err;
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [110:0] mosi_bits;
  logic [40:0]  miso_bits;
  mosi_t mosi;
  logic v_i = 1'b0, ready_o, we_i = 1'b0, v_o, yumi_i = 1'b0, we_o;
  logic [31:0] addr_i = 32'h0, data_i = 32'h0, data_o;
  logic [3:0]  wstrb_i = 4'h0;
  logic [1:0]  resp_o;
  logic [7:0]  err_cnt_o;

  logic s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0, s_arready = 1'b0, s_rvalid = 1'b0;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;
  logic p_awvalid = 1'b0, p_wvalid = 1'b0, p_arvalid = 1'b0, p_bready = 1'b0, p_rready = 1'b0;
  logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0, p_araddr = 32'h0;
  logic [3:0] p_wstrb = 4'h0;
  logic [2:0] p_awprot = 3'h0;
  logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
  logic [3:0] cap_wstrb = 4'h0;
  int n_awhs = 0, n_whs = 0, n_bhs = 0, n_arhs = 0, n_rhs = 0;
  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0] cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  int err_model = 0;
  exp_t sbq[$];
  vec_t tbl[7];

  // auxiliary instances exercise the base-address offset
  logic [110:0] ax1_bits, ax2_bits;
  mosi_t ax1_m, ax2_m;
  logic ax_v = 1'b0;
  logic [31:0] ax1_addr = 32'h0, ax2_addr = 32'h0;
  logic ax1_ready, ax1_v, ax1_we, ax2_ready, ax2_v, ax2_we;
  logic [31:0] ax1_data, ax2_data;
  logic [1:0] ax1_resp, ax2_resp;
  logic [7:0] ax1_err, ax2_err;

  assign mosi = mosi_bits;
  assign ax1_m = ax1_bits;
  assign ax2_m = ax2_bits;
  assign miso_bits = {s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid};

  bsg_axil_master_cmd #(.axil_base_addr_p(32'h0000_0000), .err_cnt_width_p(8)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .m_axil_bus_o(mosi_bits), .m_axil_bus_i(miso_bits),
    .v_i(v_i), .ready_o(ready_o), .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .wstrb_i(wstrb_i),
    .v_o(v_o), .yumi_i(yumi_i), .we_o(we_o), .data_o(data_o), .resp_o(resp_o), .err_cnt_o(err_cnt_o));

  bsg_axil_master_cmd #(.axil_base_addr_p(32'h0000_1000), .err_cnt_width_p(8)) u_ax1 (
    .clk_i(clk), .reset_n_i(rst_n), .m_axil_bus_o(ax1_bits), .m_axil_bus_i(41'd0),
    .v_i(ax_v), .ready_o(ax1_ready), .we_i(1'b0), .addr_i(ax1_addr), .data_i(32'h0), .wstrb_i(4'h0),
    .v_o(ax1_v), .yumi_i(1'b0), .we_o(ax1_we), .data_o(ax1_data), .resp_o(ax1_resp), .err_cnt_o(ax1_err));

  bsg_axil_master_cmd #(.axil_base_addr_p(32'hFFFF_F000), .err_cnt_width_p(8)) u_ax2 (
    .clk_i(clk), .reset_n_i(rst_n), .m_axil_bus_o(ax2_bits), .m_axil_bus_i(41'd0),
    .v_i(ax_v), .ready_o(ax2_ready), .we_i(1'b0), .addr_i(ax2_addr), .data_i(32'h0), .wstrb_i(4'h0),
    .v_o(ax2_v), .yumi_i(1'b0), .we_o(ax2_we), .data_o(ax2_data), .resp_o(ax2_resp), .err_cnt_o(ax2_err));

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Behavioural slave and protocol monitor, evaluated on the falling edge.
  initial begin
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done, ar_done;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awvalid = 1'b0; p_wvalid = 1'b0; p_arvalid = 1'b0; p_bready = 1'b0; p_rready = 1'b0;
      end else begin
        aw_hs = p_awvalid & s_awready;
        w_hs  = p_wvalid  & s_wready;
        ar_hs = p_arvalid & s_arready;
        b_hs  = s_bvalid  & p_bready;
        r_hs  = s_rvalid  & p_rready;
        if (p_awvalid && !s_awready) begin
          check32("awvalid_hold", 32'(mosi.awvalid), 32'd1);
          check32("awaddr_hold", mosi.awaddr, p_awaddr);
        end
        if (p_wvalid && !s_wready) begin
          check32("wvalid_hold", 32'(mosi.wvalid), 32'd1);
          check32("wdata_hold", mosi.wdata, p_wdata);
        end
        if (p_arvalid && !s_arready) check32("arvalid_hold", 32'(mosi.arvalid), 32'd1);
        if (aw_hs) begin
          check32("awvalid_drop", 32'(mosi.awvalid), 32'd0);
          check32("awprot", 32'(p_awprot), 32'd0);
          cap_awaddr = p_awaddr; aw_done = 1'b1; n_awhs++;
        end
        if (w_hs) begin
          check32("wvalid_drop", 32'(mosi.wvalid), 32'd0);
          cap_wdata = p_wdata; cap_wstrb = p_wstrb; w_done = 1'b1; n_whs++;
        end
        if (ar_hs) begin
          check32("arvalid_drop", 32'(mosi.arvalid), 32'd0);
          cap_araddr = p_araddr; ar_done = 1'b1; n_arhs++;
        end
        if (b_hs) begin
          s_bvalid = 1'b0; aw_done = 1'b0; w_done = 1'b0; b_cnt = 0; n_bhs++;
        end
        if (r_hs) begin
          s_rvalid = 1'b0; ar_done = 1'b0; r_cnt = 0; n_rhs++;
        end
        if (mosi.awvalid) begin
          if (aw_cnt >= cfg_aw_dly) s_awready = 1'b1; else begin s_awready = 1'b0; aw_cnt++; end
        end else begin s_awready = 1'b0; aw_cnt = 0; end
        if (mosi.wvalid) begin
          if (w_cnt >= cfg_w_dly) s_wready = 1'b1; else begin s_wready = 1'b0; w_cnt++; end
        end else begin s_wready = 1'b0; w_cnt = 0; end
        if (mosi.arvalid) begin
          if (ar_cnt >= cfg_ar_dly) s_arready = 1'b1; else begin s_arready = 1'b0; ar_cnt++; end
        end else begin s_arready = 1'b0; ar_cnt = 0; end
        if (aw_done && w_done && !s_bvalid) begin
          if (b_cnt >= cfg_b_dly) begin s_bvalid = 1'b1; s_bresp = cfg_resp; end else b_cnt++;
        end
        if (ar_done && !s_rvalid) begin
          if (r_cnt >= cfg_r_dly) begin
            s_rvalid = 1'b1; s_rdata = cfg_rdata; s_rresp = cfg_resp;
          end else r_cnt++;
        end
        p_awvalid = mosi.awvalid; p_awaddr = mosi.awaddr; p_awprot = mosi.awprot;
        p_wvalid = mosi.wvalid; p_wdata = mosi.wdata; p_wstrb = mosi.wstrb;
        p_arvalid = mosi.arvalid; p_araddr = mosi.araddr;
        p_bready = mosi.bready; p_rready = mosi.rready;
      end
    end
  end

  task automatic run_cmd(input vec_t v);
    exp_t e, got;
    int n, lat, nb0, naw0, nw0, nar0;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_resp = v.resp; cfg_rdata = v.rdata;
    n = 0;
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    check32("ready_wait", 32'(ready_o), 32'd1);
    if (!ready_o) return;
    nb0 = n_bhs; naw0 = n_awhs; nw0 = n_whs; nar0 = n_arhs;
    we_i = v.we; addr_i = v.addr; data_i = v.data; wstrb_i = v.strb; v_i = 1'b1;
    @(posedge clk);
    if (v.exp_resp != 2'b00 && err_model < 255) err_model++;
    e = '{we: v.we, data: v.exp_data, resp: v.exp_resp, err: err_model,
          addr: v.addr, wdata: v.data, wstrb: v.strb};
    sbq.push_back(e);
    @(negedge clk);
    v_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; data_i = $urandom; wstrb_i = 4'($urandom);
    lat = 0;
    while (!v_o && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
    check32("v_o_timeout", 32'(v_o), 32'd1);
    if (v.exp_lat >= 0) check32("latency", lat, v.exp_lat);
    for (int i = 0; i < v.yumi_dly; i++) begin
      check32("v_o_hold", 32'(v_o), 32'd1);
      check32("data_o_hold", data_o, e.data);
      @(negedge clk);
    end
    yumi_i = 1'b1;
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      check32("we_o", 32'(we_o), 32'(got.we));
      check32("data_o", data_o, got.data);
      check32("resp_o", 32'(resp_o), 32'(got.resp));
      check32("err_cnt_o", 32'(err_cnt_o), got.err);
      if (got.we) begin
        check32("awaddr", cap_awaddr, got.addr);
        check32("wdata", cap_wdata, got.wdata);
        check32("wstrb", 32'(cap_wstrb), 32'(got.wstrb));
        check32("aw_beats", n_awhs, naw0 + 1);
        check32("w_beats", n_whs, nw0 + 1);
        check32("b_beats", n_bhs, nb0 + 1);
      end else begin
        check32("araddr", cap_araddr, got.addr);
        check32("ar_beats", n_arhs, nar0 + 1);
        check32("b_beats_rd", n_bhs, nb0);
      end
    end else begin
      check32("sb_empty", 32'(sbq.size()), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    yumi_i = 1'b0;
    check32("v_o_after_yumi", 32'(v_o), 32'd0);
    check32("ready_after_yumi", 32'(ready_o), 32'd1);
  endtask

  initial begin
    vec_t sv;
    //          we    addr          data          strb aw w  b  ar r  resp   rdata         yd exp_data      exp_resp lat
    tbl[0] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 32'h0,         2'b00,  2};
    tbl[1] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 0, 2, 5, 2'b00, 32'h0000_0004, 3, 32'h0000_0004, 2'b00, -1};
    tbl[2] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'h3, 0, 4, 0, 0, 0, 2'b00, 32'h0,         0, 32'h0,         2'b00, -1};
    tbl[3] = '{1'b1, 32'h0000_0048, 32'hA5A5_5A5A, 4'hC, 4, 0, 2, 0, 0, 2'b00, 32'h0,         1, 32'h0,         2'b00, -1};
    tbl[4] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2'b11, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 2'b11, -1};
    tbl[5] = '{1'b1, 32'h0000_00FC, 32'h0000_0000, 4'h1, 0, 0, 3, 0, 0, 2'b01, 32'h0,         0, 32'h0,         2'b01, -1};
    tbl[6] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 2'b00,  2};

    #1;
    check32("rst_ready", 32'(ready_o), 32'd0);
    check32("rst_v_o", 32'(v_o), 32'd0);
    check32("rst_we_o", 32'(we_o), 32'd0);
    check32("rst_data_o", data_o, 32'd0);
    check32("rst_resp_o", 32'(resp_o), 32'd0);
    check32("rst_err", 32'(err_cnt_o), 32'd0);
    check32("rst_valids", 32'({mosi.awvalid, mosi.wvalid, mosi.arvalid, mosi.bready, mosi.rready}), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check32("ready_after_release", 32'(ready_o), 32'd1);

    for (int i = 0; i < 7; i++) run_cmd(tbl[i]);

    // base-address offset and 32-bit wraparound
    check32("ax1_ready", 32'(ax1_ready), 32'd1);
    ax_v = 1'b1; ax1_addr = 32'h0000_0020; ax2_addr = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    ax_v = 1'b0;
    check32("ax1_arvalid", 32'(ax1_m.arvalid), 32'd1);
    check32("ax1_araddr", ax1_m.araddr, 32'h0000_1020);
    check32("ax2_arvalid", 32'(ax2_m.arvalid), 32'd1);
    check32("ax2_araddr", ax2_m.araddr, 32'h0000_0000);

    // error counter saturation
    sv = '{1'b1, 32'h0000_0020, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h0, 0, 32'h0, 2'b10, 2};
    for (int i = 0; i < 300; i++) begin
      sv.data = $urandom;
      run_cmd(sv);
    end
    check32("err_saturated", 32'(err_cnt_o), 32'd255);

    // reset while a write is stalled in WR
    cfg_aw_dly = 10; cfg_w_dly = 10; cfg_resp = 2'b00;
    @(negedge clk);
    we_i = 1'b1; addr_i = 32'h0000_0030; data_i = 32'h0BAD_CAFE; wstrb_i = 4'hF; v_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    @(negedge clk);
    check32("pre_rst_awvalid", 32'(mosi.awvalid), 32'd1);
    check32("pre_rst_wvalid", 32'(mosi.wvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check32("mid_rst_awvalid", 32'(mosi.awvalid), 32'd0);
    check32("mid_rst_wvalid", 32'(mosi.wvalid), 32'd0);
    check32("mid_rst_v_o", 32'(v_o), 32'd0);
    check32("mid_rst_ready", 32'(ready_o), 32'd0);
    sbq.delete();
    err_model = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check32("post_rst_ready", 32'(ready_o), 32'd1);
    check32("post_rst_err", 32'(err_cnt_o), 32'd0);
    check32("post_rst_v_o", 32'(v_o), 32'd0);
    @(negedge clk);
    run_cmd(tbl[0]);
    run_cmd(tbl[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
